// File: rtl/sort_sequencer_pkg.sv
// Shared types and helpers for the sort sequencer: FSM states, transposition phase,
// padding word and comparator pair steering.
package sort_sequencer_pkg;

    typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

    typedef enum logic {PhaseEven, PhaseOdd} phase_e;

    // Unused slots hold the largest value so they settle at the top and are never drained.
    localparam logic [63:0] PadWord = '1;

    function automatic int unsigned pair_lo(phase_e phase, int unsigned i);
        return (phase == PhaseEven) ? 2 * i : 2 * i + 1;
    endfunction

    // In the odd phase the last comparator has no partner; it sees the top slot twice.
    function automatic int unsigned pair_hi(phase_e phase, int unsigned i, int unsigned n);
        if (phase == PhaseEven) begin
            return 2 * i + 1;
        end
        return (2 * i + 2 < n) ? 2 * i + 2 : 2 * i + 1;
    endfunction

endpackage

// File: rtl/sort_sequencer_if.sv
// Load/drain handshake bundle of the sort sequencer.
interface sort_sequencer_if #(
    parameter int unsigned W = 4
);
    logic         in_valid;
    logic [W-1:0] in_bits;
    logic         in_last;
    logic         in_ready;
    logic         have_output;
    logic [W-1:0] out_bits;
    logic         busy;

    modport master (
        output in_valid, in_bits, in_last,
        input  in_ready, have_output, out_bits, busy
    );

    modport slave (
        input  in_valid, in_bits, in_last,
        output in_ready, have_output, out_bits, busy
    );
endinterface

// File: rtl/cmp_swap.sv
// Unsigned compare-exchange cell: orders two elements and flags when they were out of order.
module cmp_swap #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] min_o,
    output logic [W-1:0] max_o,
    output logic         swapped_o
);
    always_comb begin
        swapped_o = a_i > b_i;
        min_o     = swapped_o ? b_i : a_i;
        max_o     = swapped_o ? a_i : b_i;
    end
endmodule

// File: rtl/sort_sequencer.sv
// Load / odd-even transposition sort / drain sequencer.
// Optional SORT_EARLY_EXIT_EN ends SORT after two consecutive swap-free phases.
module sort_sequencer
    import sort_sequencer_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            reset,
    sort_sequencer_if.slave bus
);
    localparam int unsigned Half = N / 2;
    localparam int unsigned CntW = $clog2(N + 1);
    localparam int unsigned IdxW = $clog2(N);

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] step_q, step_d;
    logic [W-1:0]    slot_q [N];
    logic [W-1:0]    slot_d [N];

    logic [W-1:0]    cmp_a   [Half];
    logic [W-1:0]    cmp_b   [Half];
    logic [W-1:0]    cmp_min [Half];
    logic [W-1:0]    cmp_max [Half];
    logic [Half-1:0] cmp_swapped;
    logic            sort_done;

    always_comb begin
        for (int i = 0; i < int'(Half); i++) begin
            cmp_a[i] = slot_q[IdxW'(pair_lo(phase_q, i))];
            cmp_b[i] = slot_q[IdxW'(pair_hi(phase_q, i, N))];
        end
    end

    for (genvar g = 0; g < int'(Half); g++) begin : g_cmp
        cmp_swap #(.W(W)) u_cmp (
            .a_i       (cmp_a[g]),
            .b_i       (cmp_b[g]),
            .min_o     (cmp_min[g]),
            .max_o     (cmp_max[g]),
            .swapped_o (cmp_swapped[g])
        );
    end

`ifdef SORT_EARLY_EXIT_EN
    logic prev_clean_q, prev_clean_d;
    logic any_swap;

    // prev_clean_q is low on the first SORT cycle, so at least two phases always run.
    always_comb begin
        any_swap     = |cmp_swapped;
        prev_clean_d = (state_q == StSort) && !any_swap;
        sort_done    = (step_q == IdxW'(N - 1)) || (prev_clean_q && !any_swap);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_clean_q <= 1'b0;
        end else begin
            prev_clean_q <= prev_clean_d;
        end
    end
`else
    logic unused_swapped;

    always_comb begin
        unused_swapped = ^cmp_swapped;
        sort_done      = step_q == IdxW'(N - 1);
    end
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        slot_d  = slot_q;
        unique case (state_q)
            StLoad: begin
                if (bus.in_valid) begin
                    slot_d[cnt_q[IdxW-1:0]] = bus.in_bits;
                    cnt_d = cnt_q + 1'b1;
                    if (bus.in_last || cnt_d == CntW'(N)) begin
                        for (int i = 0; i < int'(N); i++) begin
                            if (i > int'(cnt_q)) begin
                                slot_d[i] = PadWord[W-1:0];
                            end
                        end
                        state_d = StSort;
                        phase_d = PhaseEven;
                        step_d  = '0;
                    end
                end
            end
            StSort: begin
                for (int i = 0; i < int'(Half); i++) begin
                    slot_d[IdxW'(pair_lo(phase_q, i))]    = cmp_min[i];
                    slot_d[IdxW'(pair_hi(phase_q, i, N))] = cmp_max[i];
                end
                phase_d = (phase_q == PhaseEven) ? PhaseOdd : PhaseEven;
                step_d  = step_q + 1'b1;
                if (sort_done) begin
                    state_d = StDrain;
                    step_d  = '0;
                end
            end
            StDrain: begin
                step_d = step_q + 1'b1;
                if (CntW'(step_q) + CntW'(1) == cnt_q) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        bus.in_ready    = state_q == StLoad;
        bus.have_output = state_q == StDrain;
        bus.busy        = state_q != StLoad;
        bus.out_bits    = (state_q == StDrain) ? slot_q[step_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
            phase_q <= PhaseEven;
            cnt_q   <= '0;
            step_q  <= '0;
            for (int i = 0; i < int'(N); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            for (int i = 0; i < int'(N); i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule
